// File: rtl/risk_tile_copy.sv
// risk_tile_copy: walks one 2D tile-copy command tile by tile and drives the
// risk block with a LOAD into a staging register followed by a STORE of that
// register to the destination, for every 4x4 tile (tx inner, ty outer).
module risk_tile_copy #(
    parameter int REG      = 0,
    parameter int LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [16:0] cmd_src,
    input  logic [16:0] cmd_dst,
    input  logic [14:0] cmd_stride_x,
    input  logic [14:0] cmd_stride_y,
    input  logic [7:0]  cmd_tiles_x,
    input  logic [7:0]  cmd_tiles_y,
    output logic [2:0]  risk_func,
    output logic [4:0]  risk_reg,
    output logic [16:0] risk_addr,
    output logic [14:0] risk_stride_x,
    output logic [14:0] risk_stride_y,
    output logic        busy,
    output logic        done
);

    localparam int LAT_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

    localparam logic [2:0] FUNC_LOAD  = 3'b000;
    localparam logic [2:0] FUNC_STORE = 3'b001;
    localparam logic [2:0] FUNC_NOP   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD,
        S_ST_SETUP,
        S_ST,
        S_ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        func_q, func_d;
    logic [16:0]       addr_q, addr_d;
    logic [14:0]       stride_x_q, stride_x_d;
    logic [14:0]       stride_y_q, stride_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [7:0]        tiles_x_q, tiles_x_d;
    logic [7:0]        tiles_y_q, tiles_y_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        ty_q, ty_d;
    logic [16:0]       src_row_q, src_row_d;
    logic [16:0]       dst_row_q, dst_row_d;
    logic [16:0]       src_col_q, src_col_d;
    logic [16:0]       dst_col_q, dst_col_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    // Pointer steps between tiles: four elements per tile edge (17-bit, wraps).
    logic [16:0] step_x, step_y;
    logic        last_x, last_y;

    assign step_x = {stride_x_q, 2'b00};
    assign step_y = {stride_y_q, 2'b00};
    assign last_x = (tx_q == tiles_x_q - 8'd1);
    assign last_y = (ty_q == tiles_y_q - 8'd1);

    // Next-state and next-output logic for the tile walk.
    always_comb begin
        // NOTE: every *_d starts from a default so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        func_d     = FUNC_NOP;
        addr_d     = addr_q;
        stride_x_d = stride_x_q;
        stride_y_d = stride_y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ready_d    = ready_q;
        tiles_x_d  = tiles_x_q;
        tiles_y_d  = tiles_y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        src_row_d  = src_row_q;
        dst_row_d  = dst_row_q;
        src_col_d  = src_col_q;
        dst_col_d  = dst_col_q;
        lat_d      = lat_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    stride_x_d = cmd_stride_x;
                    stride_y_d = cmd_stride_y;
                    tiles_x_d  = cmd_tiles_x;
                    tiles_y_d  = cmd_tiles_y;
                    if (cmd_tiles_x == 8'd0 || cmd_tiles_y == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_LD_WAIT;
                        busy_d    = 1'b1;
                        ready_d   = 1'b0;
                        addr_d    = cmd_src;
                        src_row_d = cmd_src;
                        src_col_d = cmd_src;
                        dst_row_d = cmd_dst;
                        dst_col_d = cmd_dst;
                        tx_d      = 8'd0;
                        ty_d      = 8'd0;
                        lat_d     = LAT_INIT;
                    end
                end
            end
            S_LD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = S_LD;
                    func_d  = FUNC_LOAD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            S_LD: begin
                state_d = S_ST_SETUP;
                addr_d  = dst_col_q;
            end
            S_ST_SETUP: begin
                state_d = S_ST;
                func_d  = FUNC_STORE;
            end
            S_ST: begin
                // The risk registers commit one cycle after STORE, so the
                // destination address is held through ST_HOLD.
                state_d = S_ST_HOLD;
            end
            S_ST_HOLD: begin
                if (last_x && last_y) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else if (last_x) begin
                    state_d   = S_LD_WAIT;
                    lat_d     = LAT_INIT;
                    tx_d      = 8'd0;
                    ty_d      = ty_q + 8'd1;
                    src_row_d = src_row_q + step_y;
                    dst_row_d = dst_row_q + step_y;
                    src_col_d = src_row_d;
                    dst_col_d = dst_row_d;
                    addr_d    = src_row_d;
                end else begin
                    state_d   = S_LD_WAIT;
                    lat_d     = LAT_INIT;
                    tx_d      = tx_q + 8'd1;
                    src_col_d = src_col_q + step_x;
                    dst_col_d = dst_col_q + step_x;
                    addr_d    = src_col_d;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; synchronous reset aborts any command.
    always_ff @(posedge clk) begin
        // NOTE: the reset clears every flop, counters and pointers included, so an aborted command leaves nothing behind.
        if (!resetn) begin
            state_q    <= S_IDLE;
            func_q     <= FUNC_NOP;
            addr_q     <= '0;
            stride_x_q <= '0;
            stride_y_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            tiles_x_q  <= '0;
            tiles_y_q  <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            src_row_q  <= '0;
            dst_row_q  <= '0;
            src_col_q  <= '0;
            dst_col_q  <= '0;
            lat_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            func_q     <= func_d;
            addr_q     <= addr_d;
            stride_x_q <= stride_x_d;
            stride_y_q <= stride_y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            tiles_x_q  <= tiles_x_d;
            tiles_y_q  <= tiles_y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            src_row_q  <= src_row_d;
            dst_row_q  <= dst_row_d;
            src_col_q  <= src_col_d;
            dst_col_q  <= dst_col_d;
            lat_q      <= lat_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign risk_func     = func_q;
    assign risk_reg      = 5'(REG);
    assign risk_addr     = addr_q;
    assign risk_stride_x = stride_x_q;
    assign risk_stride_y = stride_y_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_risk_tile_copy.sv
// Self-checking bench for risk_tile_copy: per-scenario tasks with inline
// comparisons, plus a scoreboard of expected LOAD/STORE operations that a
// negedge monitor pops whenever the DUT issues one.
module tb_risk_tile_copy;

    localparam int REG      = 0;
    localparam int LOAD_LAT = 2;
    localparam int TILE_CYC = LOAD_LAT + 4;

    localparam logic [2:0] F_LOAD  = 3'b000;
    localparam logic [2:0] F_STORE = 3'b001;
    localparam logic [2:0] F_NOP   = 3'b111;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [16:0] cmd_src;
    logic [16:0] cmd_dst;
    logic [14:0] cmd_stride_x;
    logic [14:0] cmd_stride_y;
    logic [7:0]  cmd_tiles_x;
    logic [7:0]  cmd_tiles_y;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [16:0] risk_addr;
    logic [14:0] risk_stride_x;
    logic [14:0] risk_stride_y;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [2:0]  func;
        logic [16:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    risk_tile_copy #(
        .REG      (REG),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src       (cmd_src),
        .cmd_dst       (cmd_dst),
        .cmd_stride_x  (cmd_stride_x),
        .cmd_stride_y  (cmd_stride_y),
        .cmd_tiles_x   (cmd_tiles_x),
        .cmd_tiles_y   (cmd_tiles_y),
        .risk_func     (risk_func),
        .risk_reg      (risk_reg),
        .risk_addr     (risk_addr),
        .risk_stride_x (risk_stride_x),
        .risk_stride_y (risk_stride_y),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every LOAD/STORE must match the oldest expected op.
    always @(negedge clk) begin
        if (mon_en) begin
            if (risk_func === F_LOAD || risk_func === F_STORE) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op: got func=%0d addr=%05h, required no operation", risk_func, risk_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (risk_func !== mon_e.func || risk_addr !== mon_e.addr) begin
                        bad++;
                        $display("FAIL op_order: got func=%0d addr=%05h, required func=%0d addr=%05h",
                                 risk_func, risk_addr, mon_e.func, mon_e.addr);
                    end
                end
            end else if (risk_func !== F_NOP) begin
                total++;
                bad++;
                $display("FAIL illegal_func: got func=%b, required LOAD, STORE or NOP", risk_func);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected operations straight from the address formula, modulo 2^17.
    task automatic push_cmd(input logic [16:0] src, input logic [16:0] dst,
                            input logic [14:0] sx, input logic [14:0] sy,
                            input logic [7:0] ntx, input logic [7:0] nty);
        exp_t e;
        for (int y = 0; y < int'(nty); y++) begin
            for (int x = 0; x < int'(ntx); x++) begin
                e.func = F_LOAD;
                e.addr = 17'(int'(src) + x * 4 * int'(sx) + y * 4 * int'(sy));
                exp_q.push_back(e);
                e.func = F_STORE;
                e.addr = 17'(int'(dst) + x * 4 * int'(sx) + y * 4 * int'(sy));
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_fields(input logic [16:0] src, input logic [16:0] dst,
                              input logic [14:0] sx, input logic [14:0] sy,
                              input logic [7:0] ntx, input logic [7:0] nty);
        cmd_src      = src;
        cmd_dst      = dst;
        cmd_stride_x = sx;
        cmd_stride_y = sy;
        cmd_tiles_x  = ntx;
        cmd_tiles_y  = nty;
    endtask

    // Present a command, wait for acceptance, return at the first cycle after it.
    task automatic send_cmd(input logic [16:0] src, input logic [16:0] dst,
                            input logic [14:0] sx, input logic [14:0] sy,
                            input logic [7:0] ntx, input logic [7:0] nty);
        int n;
        set_fields(src, dst, sx, sy, ntx, nty);
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        total++;
        if (n >= 1000) begin
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        tick();
        cmd_valid = 1'b0;
        push_cmd(src, dst, sx, sy, ntx, nty);
    endtask

    // Count busy cycles until done, then check the done-cycle state.
    task automatic wait_done(input int exp_busy, input string name);
        int n;
        int cnt;
        n = 0;
        cnt = 0;
        while (done !== 1'b1 && n < 2000) begin
            if (busy === 1'b1) cnt++;
            tick();
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", name, n);
            return;
        end
        total++;
        if (cnt != exp_busy) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d, required %0d", name, cnt, exp_busy);
        end
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_state: got busy=%b cmd_ready=%b, required busy=0 cmd_ready=1", name, busy, cmd_ready);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_ops_missing: %0d expected ops never issued, required 0", name, exp_q.size());
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        set_fields(17'h0, 17'h0, 15'h0, 15'h0, 8'd0, 8'd0);
        tick();
        tick();
        total++;
        if (risk_func !== F_NOP || risk_addr !== 17'h0) begin
            bad++;
            $display("FAIL reset_func_addr: got func=%b addr=%05h, required func=111 addr=00000", risk_func, risk_addr);
        end
        total++;
        if (risk_stride_x !== 15'h0 || risk_stride_y !== 15'h0) begin
            bad++;
            $display("FAIL reset_strides: got sx=%h sy=%h, required 0 0", risk_stride_x, risk_stride_y);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b done=%b cmd_ready=%b, required 0 0 1", busy, done, cmd_ready);
        end
        total++;
        if (risk_reg !== 5'(REG)) begin
            bad++;
            $display("FAIL reset_reg: got %0d, required %0d", risk_reg, REG);
        end
        resetn = 1'b1;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_single_tile();
        logic [2:0]  ef[6];
        logic [16:0] ea[6];
        ef = '{F_NOP, F_NOP, F_LOAD, F_NOP, F_STORE, F_NOP};
        ea = '{17'h100, 17'h100, 17'h100, 17'h200, 17'h200, 17'h200};
        send_cmd(17'h100, 17'h200, 15'd1, 15'd4, 8'd1, 8'd1);
        for (int i = 0; i < TILE_CYC; i++) begin
            total++;
            if (risk_func !== ef[i] || risk_addr !== ea[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_cycle%0d: got func=%b addr=%05h busy=%b, required func=%b addr=%05h busy=1",
                         i, risk_func, risk_addr, busy, ef[i], ea[i]);
            end
            tick();
        end
        wait_done(0, "single");
    endtask

    task automatic test_grid();
        send_cmd(17'h0, 17'h1000, 15'd1, 15'd32, 8'd2, 8'd2);
        total++;
        if (risk_stride_x !== 15'd1 || risk_stride_y !== 15'd32) begin
            bad++;
            $display("FAIL grid_strides: got sx=%0d sy=%0d, required 1 32", risk_stride_x, risk_stride_y);
        end
        wait_done(4 * TILE_CYC, "grid");
    endtask

    task automatic test_empty();
        send_cmd(17'h40, 17'h80, 15'd3, 15'd5, 8'd0, 8'd5);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_done: got done=%b busy=%b right after accept, required 1 0", done, busy);
        end
        wait_done(0, "empty");
    endtask

    task automatic test_wrap();
        exp_t e;
        send_cmd(17'h1FFFE, 17'h500, 15'd1, 15'd0, 8'd2, 8'd1);
        e = exp_q[2];
        total++;
        if (e.addr !== 17'h00002) begin
            bad++;
            $display("FAIL wrap_model: model second LOAD %05h, required 00002", e.addr);
        end
        wait_done(2 * TILE_CYC, "wrap");
    endtask

    task automatic test_reset_abort();
        send_cmd(17'h300, 17'h400, 15'd2, 15'd7, 8'd3, 8'd1);
        for (int i = 0; i < TILE_CYC + 3; i++) tick();
        total++;
        if (risk_func !== F_NOP || risk_addr !== 17'h408) begin
            bad++;
            $display("FAIL abort_setup: got func=%b addr=%05h, required func=111 addr=00408", risk_func, risk_addr);
        end
        total++;
        if (exp_q.size() != 3) begin
            bad++;
            $display("FAIL abort_progress: %0d ops outstanding, required 3", exp_q.size());
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_q.delete();
        total++;
        if (risk_func !== F_NOP || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: got func=%b busy=%b cmd_ready=%b done=%b, required 111 0 1 0",
                     risk_func, busy, cmd_ready, done);
        end
        for (int i = 0; i < 2 * TILE_CYC; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle%0d: got done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        send_cmd(17'h555, 17'h666, 15'd1, 15'd1, 8'd1, 8'd1);
        total++;
        if (risk_addr !== 17'h555 || risk_func !== F_NOP) begin
            bad++;
            $display("FAIL abort_restart: got func=%b addr=%05h, required func=111 addr=00555", risk_func, risk_addr);
        end
        wait_done(TILE_CYC, "restart");
    endtask

    task automatic test_back_to_back();
        int n;
        int cnt;
        send_cmd(17'h700, 17'h800, 15'd2, 15'd3, 8'd1, 8'd1);
        set_fields(17'h0A0, 17'h0B0, 15'd5, 15'd6, 8'd1, 8'd1);
        cmd_valid = 1'b1;
        push_cmd(17'h0A0, 17'h0B0, 15'd5, 15'd6, 8'd1, 8'd1);
        n = 0;
        cnt = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) cnt++;
            total++;
            if (busy === 1'b1 && (cmd_ready !== 1'b0 || risk_stride_x !== 15'd2)) begin
                bad++;
                $display("FAIL b2b_ignore: got cmd_ready=%b sx=%0d while busy, required 0 2", cmd_ready, risk_stride_x);
            end
            tick();
            n++;
        end
        total++;
        if (cnt != TILE_CYC || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got busy cycles=%0d cmd_ready=%b, required %0d 1", cnt, cmd_ready, TILE_CYC);
        end
        tick();
        cmd_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || risk_func !== F_NOP || risk_addr !== 17'h0A0) begin
            bad++;
            $display("FAIL b2b_second_start: got busy=%b func=%b addr=%05h, required 1 111 000a0", busy, risk_func, risk_addr);
        end
        total++;
        if (risk_stride_x !== 15'd5 || risk_stride_y !== 15'd6) begin
            bad++;
            $display("FAIL b2b_second_strides: got sx=%0d sy=%0d, required 5 6", risk_stride_x, risk_stride_y);
        end
        wait_done(TILE_CYC, "b2b");
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_grid();
        test_empty();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
